// File: rtl/init_led_if.sv
// LED driver chain signal bundle: latch strobe, serial data/clock and init status.
interface init_led_if;
    logic LAT;
    logic SDOsingle;
    logic SCLK;
    logic initDone;

    modport master (
        output LAT,
        output SDOsingle,
        output SCLK,
        output initDone
    );

    modport slave (
        input LAT,
        input SDOsingle,
        input SCLK,
        input initDone
    );
endinterface

// File: rtl/init_led.sv
// One-shot power-up configurator for a daisy chain of serial LED drivers.
// After a startup delay it shifts CTRL_WORD MSB-first once per driver, pulses LAT,
// then holds initDone high until the next reset.
// Optional feature macro: INITLED_DOUBLE_LATCH_EN runs the shift/gap/latch pass twice.
module init_led #(
    parameter int unsigned             CTRL_BITS      = 16,
    parameter logic [CTRL_BITS-1:0]    CTRL_WORD      = 16'hA5C3,
    parameter int unsigned             NUM_DRIVERS    = 2,
    parameter int unsigned             STARTUP_CYCLES = 16,
    parameter int unsigned             SCLK_DIV       = 1,
    parameter int unsigned             LAT_CYCLES     = 2
) (
    input  logic        spiClk,
    input  logic        reset,
    init_led_if.master  led
);

    localparam int unsigned TOTAL_BITS = CTRL_BITS * NUM_DRIVERS;
    localparam int unsigned WAIT_W     = $clog2(STARTUP_CYCLES + 1);
    localparam int unsigned DIV_W      = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int unsigned DRV_W      = $clog2(NUM_DRIVERS + 1);
    localparam int unsigned LAT_W      = $clog2(LAT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_SHIFT,
        S_GAP,
        S_LATCH,
        S_DONE
    } state_t;

    state_t                 state;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DRV_W-1:0]       drv_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [CTRL_BITS-1:0]   sr;
    logic                   lat;
    logic                   sdo;
    logic                   sclk;
    logic                   init_done;
`ifdef INITLED_DOUBLE_LATCH_EN
    logic                   second_pass;
`endif

    // Sequencer: the registered state/outputs after each edge describe that cycle.
    always_ff @(posedge spiClk) begin
        if (reset) begin
            state     <= S_WAIT;
            wait_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            drv_cnt   <= '0;
            lat_cnt   <= '0;
            sr        <= '0;
            lat       <= 1'b0;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
            init_done <= 1'b0;
`ifdef INITLED_DOUBLE_LATCH_EN
            second_pass <= 1'b0;
`endif
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(STARTUP_CYCLES)) begin
                        // first shift cycle: present MSB with SCLK low
                        state    <= S_SHIFT;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        drv_cnt  <= '0;
                        sdo      <= CTRL_WORD[CTRL_BITS-1];
                        sr       <= CTRL_WORD << 1;
                        sclk     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_W'(2 * SCLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == BIT_W'(CTRL_BITS - 1)) begin
                            // bit counter wraps at each driver word boundary
                            bit_cnt <= '0;
                            if (drv_cnt == DRV_W'(NUM_DRIVERS - 1)) begin
                                state   <= S_GAP;
                                drv_cnt <= '0;
                                sdo     <= 1'b0;
                            end else begin
                                drv_cnt <= drv_cnt + 1'b1;
                                sdo     <= CTRL_WORD[CTRL_BITS-1];
                                sr      <= CTRL_WORD << 1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sdo     <= sr[CTRL_BITS-1];
                            sr      <= sr << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        sclk    <= (div_cnt >= DIV_W'(SCLK_DIV - 1));
                    end
                end
                S_GAP: begin
                    state   <= S_LATCH;
                    lat     <= 1'b1;
                    lat_cnt <= '0;
                end
                S_LATCH: begin
                    if (lat_cnt == LAT_W'(LAT_CYCLES - 1)) begin
                        lat     <= 1'b0;
                        lat_cnt <= '0;
`ifdef INITLED_DOUBLE_LATCH_EN
                        if (!second_pass) begin
                            // straight back into a second full shift pass
                            second_pass <= 1'b1;
                            state       <= S_SHIFT;
                            div_cnt     <= '0;
                            bit_cnt     <= '0;
                            drv_cnt     <= '0;
                            sdo         <= CTRL_WORD[CTRL_BITS-1];
                            sr          <= CTRL_WORD << 1;
                            sclk        <= 1'b0;
                        end else begin
                            state     <= S_DONE;
                            init_done <= 1'b1;
                        end
`else
                        state     <= S_DONE;
                        init_done <= 1'b1;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    lat       <= 1'b0;
                    sdo       <= 1'b0;
                    sclk      <= 1'b0;
                    init_done <= 1'b1;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

    assign led.LAT       = lat;
    assign led.SDOsingle = sdo;
    assign led.SCLK      = sclk;
    assign led.initDone  = init_done;

endmodule

// File: tb/tb_init_led.sv
// Randomized-reset bench for init_led against a cycle-number reference model.
module tb_init_led;

    localparam int CB   = 16;
    localparam int ND   = 2;
    localparam int SU   = 16;
    localparam int LC   = 2;
    localparam logic [15:0] WORD = 16'hA5C3;
`ifdef INITLED_DOUBLE_LATCH_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic clk;
    logic rst;

    init_led_if la();
    init_led_if lb();

    init_led dut (
        .spiClk (clk),
        .reset  (rst),
        .led    (la)
    );

    init_led #(.SCLK_DIV(3)) dut3 (
        .spiClk (clk),
        .reset  (rst),
        .led    (lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          t;
    logic        prev_sclk;
    logic        cap_en;
    logic [63:0] cap;
    int          ncap;
    int          nlat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // Expected {LAT, SDOsingle, SCLK, initDone} at cycle tc after reset release.
    function automatic logic [3:0] model(input int tc, input int div);
        int r;
        int shift_len;
        int b;
        int ph;
        logic [15:0] w;
        w = WORD;
        r = tc;
        shift_len = CB * ND * 2 * div;
        if (r < SU) return 4'b0000;
        r -= SU;
        for (int p = 0; p < PASSES; p++) begin
            if (r < shift_len) begin
                b  = r / (2 * div);
                ph = r % (2 * div);
                return {1'b0, w[CB - 1 - (b % CB)], (ph >= div), 1'b0};
            end
            r -= shift_len;
            if (r == 0) return 4'b0000;
            r -= 1;
            if (r < LC) return 4'b1000;
            r -= LC;
        end
        return 4'b0001;
    endfunction

    // Advance one clock and compare both DUTs against the model for that cycle.
    task automatic step();
        logic [3:0] oa;
        logic [3:0] ob;
        @(posedge clk);
        #1;
        oa = {la.LAT, la.SDOsingle, la.SCLK, la.initDone};
        ob = {lb.LAT, lb.SDOsingle, lb.SCLK, lb.initDone};
        if (rst) begin
            check("reset_a", 64'(oa), 64'd0);
            check("reset_b", 64'(ob), 64'd0);
            t = 0;
        end else begin
            check("out_div1", 64'(oa), 64'(model(t, 1)));
            check("out_div3", 64'(ob), 64'(model(t, 3)));
            check("lat_and_sclk", 64'(la.LAT & la.SCLK), 64'd0);
            if (cap_en) begin
                if (la.SCLK && !prev_sclk) begin
                    cap = {cap[62:0], la.SDOsingle};
                    ncap++;
                end
                if (la.LAT) nlat++;
            end
            t++;
        end
        prev_sclk = la.SCLK;
    endtask

    initial begin
        logic [63:0] exp_cap;
        n_tests   = 0;
        n_fail    = 0;
        t         = 0;
        prev_sclk = 1'b0;
        cap_en    = 1'b0;
        cap       = '0;
        ncap      = 0;
        nlat      = 0;
        rst       = 1'b1;

        // clean power-up, full sequence plus long sticky-done window
        repeat (3) step();
        rst    = 1'b0;
        cap_en = 1'b1;
        repeat (1100) step();
        cap_en = 1'b0;

        exp_cap = '0;
        for (int i = 0; i < PASSES * ND; i++) exp_cap = {exp_cap[47:0], WORD};
        check("sclk_rises", 64'(ncap), 64'(PASSES * CB * ND));
        check("shift_bits", cap, exp_cap);
        check("lat_cycles", 64'(nlat), 64'(PASSES * LC));

        // abort mid-shift at cycle 40 and restart
        rst = 1'b1;
        step();
        rst = 1'b0;
        while (t < 40) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (300) step();

        // random reset pulses landing in arbitrary states
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
